// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad entry path.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HOLD
  } state_e;

  // Nibble at [4*idx +: 4] is the hex code of the key at idx = {row, col}.
  localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [3:0] idx);
    return KEYMAP[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Column scanner: drives one column low per SCAN_DIV cycles, synchronizes rows and
// classifies each full 4-column scan as a single key or nothing (scan_done pulses on the last dwell of col 3).
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 2500
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic       scan_done_o,
  output logic       scan_hit_o,
  output logic [3:0] scan_key_o
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    row_s1_q, row_s2_q;
  logic [1:0]    hits_q, hits_d;
  logic          ghost_q, ghost_d;
  logic [3:0]    idx_q, idx_d;

  logic          last_dwell;
  logic          first_col;
  logic [3:0]    row_low;
  logic [2:0]    row_cnt;
  logic [1:0]    row_enc;

  always_comb begin
    row_low = ~row_s2_q;
    row_cnt = '0;
    row_enc = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_low[r]) begin
        row_cnt = row_cnt + 3'd1;
        row_enc = 2'(r);
      end
    end

    last_dwell = (dwell_q == DWELL_LAST);
    first_col  = (col_q == 2'd0);
    dwell_d    = last_dwell ? '0 : dwell_q + 1'b1;
    col_d      = last_dwell ? col_q + 2'd1 : col_q;

    // Merge this column into the running scan; column 0 starts a fresh scan.
    hits_d  = first_col ? 2'd0 : hits_q;
    ghost_d = first_col ? 1'b0 : ghost_q;
    idx_d   = first_col ? 4'd0 : idx_q;
    if (row_cnt == 3'd1) begin
      hits_d = (hits_d == 2'd0) ? 2'd1 : 2'd2;
      idx_d  = {row_enc, col_q};
    end
    if (row_cnt > 3'd1) begin
      ghost_d = 1'b1;
    end

    scan_done_o = last_dwell && (col_q == 2'd3);
    scan_hit_o  = (hits_d == 2'd1) && !ghost_d;
    scan_key_o  = key_lookup(idx_d);
  end

  assign col_o = ~(4'b0001 << col_q);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      dwell_q  <= '0;
      col_q    <= '0;
      row_s1_q <= 4'b1111;
      row_s2_q <= 4'b1111;
      hits_q   <= '0;
      ghost_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      dwell_q  <= dwell_d;
      col_q    <= col_d;
      row_s1_q <= row_i;
      row_s2_q <= row_s1_q;
      if (last_dwell) begin
        hits_q  <= hits_d;
        ghost_q <= ghost_d;
        idx_q   <= idx_d;
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry top: debounce FSM over full scans, shifts accepted hex digits into a 16-bit value.
// key_valid pulses one cycle after the accepting scan; holding a key never repeats.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 2500,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [3:0]  row_i,
  input  logic        clear_i,
  output logic [3:0]  col_o,
  output logic [15:0] value_o,
  output logic [3:0]  key_code_o,
  output logic        key_valid_o,
  output logic [2:0]  digit_count_o
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  logic       scan_done;
  logic       scan_hit;
  logic [3:0] scan_key;

  keypad_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .row_i      (row_i),
    .col_o      (col_o),
    .scan_done_o(scan_done),
    .scan_hit_o (scan_hit),
    .scan_key_o (scan_key)
  );

  state_e        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rel_q, rel_d;
  logic [15:0]   value_q, value_d;
  logic [2:0]    digit_count_q, digit_count_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          accept;
  logic [3:0]    accept_code;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    accept      = 1'b0;
    accept_code = cand_q;

    if (scan_done) begin
      case (state_q)
        IDLE: begin
          if (scan_hit) begin
            cand_d = scan_key;
            cnt_d  = CW'(1);
            if (CNT_MAX == CW'(1)) begin
              accept      = 1'b1;
              accept_code = scan_key;
              state_d     = HOLD;
              cnt_d       = '0;
              rel_d       = '0;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (scan_hit && (scan_key == cand_q)) begin
            if (cnt_q + 1'b1 == CNT_MAX) begin
              accept  = 1'b1;
              state_d = HOLD;
              cnt_d   = '0;
              rel_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HOLD: begin
          // Any key, even a different one, keeps us waiting for a clean release.
          if (scan_hit) begin
            rel_d = '0;
          end else if (rel_q + 1'b1 == CNT_MAX) begin
            state_d = IDLE;
            rel_d   = '0;
          end else begin
            rel_d = rel_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = '0;
        end
      endcase
    end

    key_valid_d   = accept;
    key_code_d    = accept ? accept_code : key_code_q;
    value_d       = value_q;
    digit_count_d = digit_count_q;
    if (clear_i) begin
      value_d       = '0;
      digit_count_d = '0;
    end else if (accept) begin
      value_d = {value_q[11:0], accept_code};
      if (digit_count_q != 3'd4) begin
        digit_count_d = digit_count_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q       <= IDLE;
      cand_q        <= '0;
      cnt_q         <= '0;
      rel_q         <= '0;
      value_q       <= '0;
      digit_count_q <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      rel_q         <= rel_d;
      value_q       <= value_d;
      digit_count_q <= digit_count_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
    end
  end

  assign value_o       = value_q;
  assign digit_count_o = digit_count_q;
  assign key_code_o    = key_code_q;
  assign key_valid_o   = key_valid_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with SCAN_DIV=4, DEBOUNCE_SCANS=2 and a keypad matrix model.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic [15:0] value_o;
  logic [3:0]  key_code_o;
  logic        key_valid_o;
  logic [2:0]  digit_count_o;

  logic [15:0] pressed = '0;
  int          vectors = 0;
  int          errors = 0;
  int          cyc = 0;
  int          since_rst = 0;
  int          pulse_cnt = 0;
  int          first_pulse = -1;
  logic [3:0]  last_code = '0;

  always #5 clk = ~clk;

  // A pressed key at {r,c} pulls row r low while column c is driven low.
  always_comb begin
    row_i = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
      end
    end
  end

  keypad_entry #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .row_i        (row_i),
    .clear_i      (clear_i),
    .col_o        (col_o),
    .value_o      (value_o),
    .key_code_o   (key_code_o),
    .key_valid_o  (key_valid_o),
    .digit_count_o(digit_count_o)
  );

  task automatic tick();
    @(posedge clk);
    if (!reset_i) since_rst = 0;
    else since_rst++;
    cyc++;
    #1;
    if (key_valid_o === 1'b1) begin
      pulse_cnt++;
      last_code = key_code_o;
      if (first_pulse < 0) first_pulse = cyc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic press_release(input int idx, input int hold, input int gap);
    pressed = '0;
    pressed[idx] = 1'b1;
    run(hold);
    pressed = '0;
    run(gap);
  endtask

  task automatic align16();
    while (since_rst % 16 != 0) tick();
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    reset_i = 1'b0;
    pressed = '0;
    tick();
    tick();
    vectors++; if (col_o !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", col_o); end
    vectors++; if (value_o !== 16'h0) begin errors++; $display("FAIL reset_value: got %h expected 0000", value_o); end
    vectors++; if (key_code_o !== 4'h0) begin errors++; $display("FAIL reset_key_code: got %h expected 0", key_code_o); end
    vectors++; if (key_valid_o !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", key_valid_o); end
    vectors++; if (digit_count_o !== 3'd0) begin errors++; $display("FAIL reset_digit_count: got %0d expected 0", digit_count_o); end
    reset_i = 1'b1;
    pulse_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      exp_col = ~(4'b0001 << ((since_rst / 4) % 4));
      vectors++;
      if (col_o !== exp_col) begin
        errors++;
        $display("FAIL idle_col cycle %0d: got %b expected %b", since_rst, col_o, exp_col);
      end
    end
    vectors++; if (value_o !== 16'h0) begin errors++; $display("FAIL idle_value: got %h expected 0000", value_o); end
    vectors++; if (pulse_cnt !== 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", pulse_cnt); end
  endtask

  task automatic test_single_key();
    int t0;
    pulse_cnt = 0;
    first_pulse = -1;
    t0 = cyc;
    pressed[6] = 1'b1;
    run(80);
    pressed = '0;
    run(64);
    vectors++; if (pulse_cnt !== 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", pulse_cnt); end
    vectors++; if (last_code !== 4'h6) begin errors++; $display("FAIL single_code: got %h expected 6", last_code); end
    vectors++; if (value_o !== 16'h0006) begin errors++; $display("FAIL single_value: got %h expected 0006", value_o); end
    vectors++; if (digit_count_o !== 3'd1) begin errors++; $display("FAIL single_digits: got %0d expected 1", digit_count_o); end
    vectors++;
    if ((first_pulse >= 0 && first_pulse - t0 <= 51) !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles expected <= 51", first_pulse - t0);
    end
  endtask

  task automatic test_sequence();
    int         idxs[5] = '{0, 3, 12, 13, 8};
    logic [3:0] codes[5] = '{4'h1, 4'hA, 4'h0, 4'hF, 4'h7};
    pulse_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      press_release(idxs[i], 64, 64);
      vectors++;
      if (last_code !== codes[i]) begin
        errors++;
        $display("FAIL seq_code[%0d]: got %h expected %h", i, last_code, codes[i]);
      end
    end
    vectors++; if (pulse_cnt !== 5) begin errors++; $display("FAIL seq_pulses: got %0d expected 5", pulse_cnt); end
    vectors++; if (value_o !== 16'hA0F7) begin errors++; $display("FAIL seq_value: got %h expected a0f7", value_o); end
    vectors++; if (digit_count_o !== 3'd4) begin errors++; $display("FAIL seq_digits: got %0d expected 4", digit_count_o); end
  endtask

  task automatic test_bounce();
    pulse_clear();
    vectors++; if (value_o !== 16'h0) begin errors++; $display("FAIL clear_value: got %h expected 0000", value_o); end
    vectors++; if (digit_count_o !== 3'd0) begin errors++; $display("FAIL clear_digits: got %0d expected 0", digit_count_o); end
    pulse_cnt = 0;
    // Start on an even scan phase so the column-0 samples never see two consecutive presses.
    if (since_rst % 2 != 0) tick();
    for (int i = 0; i < 60; i++) begin
      pressed[0] = ((i / 3) % 2 == 0);
      tick();
    end
    vectors++; if (pulse_cnt !== 0) begin errors++; $display("FAIL bounce_pulses: got %0d expected 0", pulse_cnt); end
    pressed[0] = 1'b1;
    run(64);
    pressed = '0;
    run(64);
    vectors++; if (pulse_cnt !== 1) begin errors++; $display("FAIL bounce_stable_pulses: got %0d expected 1", pulse_cnt); end
    vectors++; if (last_code !== 4'h1) begin errors++; $display("FAIL bounce_code: got %h expected 1", last_code); end
    vectors++; if (value_o !== 16'h0001) begin errors++; $display("FAIL bounce_value: got %h expected 0001", value_o); end
  endtask

  task automatic test_ghost();
    pulse_cnt = 0;
    pressed = '0;
    pressed[0] = 1'b1;
    pressed[9] = 1'b1;
    run(100);
    vectors++; if (pulse_cnt !== 0) begin errors++; $display("FAIL ghost_pulses: got %0d expected 0", pulse_cnt); end
    pressed[9] = 1'b0;
    run(64);
    pressed = '0;
    run(64);
    vectors++; if (pulse_cnt !== 1) begin errors++; $display("FAIL ghost_release_pulses: got %0d expected 1", pulse_cnt); end
    vectors++; if (last_code !== 4'h1) begin errors++; $display("FAIL ghost_code: got %h expected 1", last_code); end
    vectors++; if (value_o !== 16'h0011) begin errors++; $display("FAIL ghost_value: got %h expected 0011", value_o); end
    vectors++; if (digit_count_o !== 3'd2) begin errors++; $display("FAIL ghost_digits: got %0d expected 2", digit_count_o); end
  endtask

  task automatic test_clear_on_accept();
    pulse_clear();
    press_release(0, 64, 64);
    press_release(1, 64, 64);
    press_release(2, 64, 64);
    press_release(4, 64, 64);
    vectors++; if (value_o !== 16'h1234) begin errors++; $display("FAIL preclear_value: got %h expected 1234", value_o); end
    align16();
    pulse_cnt = 0;
    // Key 5 sits in column 1: first matching scan ends 16 cycles out, accept on the next scan end.
    pressed[5] = 1'b1;
    run(31);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    vectors++; if (key_valid_o !== 1'b1) begin errors++; $display("FAIL clracc_valid: got %b expected 1", key_valid_o); end
    vectors++; if (key_code_o !== 4'h5) begin errors++; $display("FAIL clracc_code: got %h expected 5", key_code_o); end
    vectors++; if (value_o !== 16'h0) begin errors++; $display("FAIL clracc_value: got %h expected 0000", value_o); end
    vectors++; if (digit_count_o !== 3'd0) begin errors++; $display("FAIL clracc_digits: got %0d expected 0", digit_count_o); end
    run(32);
    pressed = '0;
    run(64);
    vectors++; if (pulse_cnt !== 1) begin errors++; $display("FAIL clracc_pulses: got %0d expected 1", pulse_cnt); end
  endtask

  task automatic test_reset_mid_debounce();
    press_release(6, 64, 64);
    vectors++; if (value_o !== 16'h0006) begin errors++; $display("FAIL prereset_value: got %h expected 0006", value_o); end
    align16();
    pulse_cnt = 0;
    pressed[10] = 1'b1;
    run(20);
    reset_i = 1'b0;
    pressed = '0;
    tick();
    tick();
    vectors++; if (col_o !== 4'b1110) begin errors++; $display("FAIL midrst_col: got %b expected 1110", col_o); end
    vectors++; if (value_o !== 16'h0) begin errors++; $display("FAIL midrst_value: got %h expected 0000", value_o); end
    vectors++; if (key_code_o !== 4'h0) begin errors++; $display("FAIL midrst_key_code: got %h expected 0", key_code_o); end
    vectors++; if (key_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_key_valid: got %b expected 0", key_valid_o); end
    vectors++; if (digit_count_o !== 3'd0) begin errors++; $display("FAIL midrst_digits: got %0d expected 0", digit_count_o); end
    reset_i = 1'b1;
    run(64);
    vectors++; if (pulse_cnt !== 0) begin errors++; $display("FAIL midrst_pulses: got %0d expected 0", pulse_cnt); end
    vectors++; if (value_o !== 16'h0) begin errors++; $display("FAIL midrst_value_after: got %h expected 0000", value_o); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_sequence();
    test_bounce();
    test_ghost();
    test_clear_on_accept();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart to the 4-digit seven-segment output path: scans a 4x4 hex keypad and debounces it.
- Each accepted key is decoded to a hex nibble and shifted into a 16-bit value.
- The value feeds the same 16-bit display/counter datapath that the multiplexed display already renders.
- Runs on the board clock; the scan rate is set by an internal divider.

Parameters:
- SCAN_DIV, 2500: clock cycles each column is driven; must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans needed to accept a press, and consecutive empty scans needed to accept a release; must be >= 1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-low reset.
- row, input, 4: keypad rows, active-low, externally pulled up, asynchronous.
- clear, input, 1: synchronous clear of value and digit_count.
- col, output, 4: keypad column drive, active-low, one-hot-low.
- value, output, 16: entered digits; newest digit in [3:0].
- key_code, output, 4: last accepted key.
- key_valid, output, 1: one-cycle pulse on acceptance.
- digit_count, output, 3: digits entered since clear/reset, saturates at 4.

Behaviour:
- Reset (reset==0 at posedge):
  - col=4'b1110, value=0, key_code=0, key_valid=0, digit_count=0.
  - FSM=IDLE; all counters and synchronizer flops = 0/idle (synchronizer flops to 4'b1111).
  - Reset mid-debounce or mid-hold discards everything in progress.
- Row synchronizer: two flops; sampled rows = synchronizer output.
- Column scan:
  - Dwell counter runs 0..SCAN_DIV-1; col index c steps 0..3 and wraps.
  - col = ~(4'b0001 << c).
  - Rows are sampled on the last dwell cycle (dwell==SCAN_DIV-1), so the 2-flop latency settles.
- Per-column result: exactly one row low = hit (r,c); zero rows = none; two or more rows = ghost.
- Per-scan result (evaluated when c==3 dwell ends, called scan_done):
  - KEY(k) if exactly one hit in the scan and no ghost.
  - Otherwise NONE; multi-key presses are ignored.
- Key map, code at (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- FSM, evaluated only on scan_done:
  - IDLE: KEY(k) -> DEBOUNCE, cand=k, cnt=1. If DEBOUNCE_SCANS==1, accept immediately and go to HOLD.
  - DEBOUNCE: KEY(cand) -> cnt+1; when cnt reaches DEBOUNCE_SCANS, accept and go to HOLD. KEY(other) or NONE -> IDLE, cnt=0.
  - HOLD: NONE -> rel+1; rel reaches DEBOUNCE_SCANS -> IDLE. Any KEY -> rel=0.
- Accept, same cycle as scan_done:
  - Next cycle: key_valid=1 for exactly 1 cycle, key_code=cand.
  - value <= {value[11:0], cand}; digit_count <= min(digit_count+1, 4).
  - value wraps by shifting: the oldest digit is lost after the 4th entry.
- clear:
  - value=0, digit_count=0 next cycle; does not affect scan or FSM.
  - If clear coincides with an accept, clear wins for value/digit_count (both 0), but key_valid and key_code still update.
- Latency: press stable from cycle t yields key_valid no later than t + 2 + (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 1.
- Holding a key produces exactly one key_valid; no auto-repeat.

Decomposition:
- Package keypad_pkg holds:
  - FSM state encoding (IDLE/DEBOUNCE/HOLD).
  - KEYMAP constant (16-entry 4-bit table indexed {r,c}).
  - NUM_ROWS/NUM_COLS=4.
- One sub-module, keypad_scan: divider, column driver, synchronizer, per-scan single-key/ghost detection. It emits scan_done and scan_key/scan_hit.
- Top keypad_entry holds the FSM and the value register.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, scan=16 cycles; keypad model pulls row r low while col c is low):
- Reset, then idle 100 cycles:
  - col cycles 1110,1101,1011,0111 every 4 cycles.
  - value=0, key_valid never asserted.
- Hold key (r1,c2) for 80 cycles, then release:
  - exactly one key_valid pulse with key_code=6 and value=16'h0006.
  - pulse occurs within 2+48+1 cycles of press.
- Press and release keys 1,A,0,F,7 in order, each held 64 cycles with 64-cycle gaps:
  - value=16'hA0F7, digit_count=4 (saturated), 5 key_valid pulses.
- Bounce: toggle key (r0,c0) every 3 cycles for 60 cycles, then hold stable 64 cycles:
  - no pulse during toggling; exactly one key_valid with key_code=1 after the stable hold.
- Press (r0,c0) and (r2,c1) together for 100 cycles:
  - no key_valid. Releasing (r2,c1) while holding (r0,c0) gives one key_valid with key_code=1.
- With value=16'h1234, assert clear on the accept cycle of key 5:
  - value=0, digit_count=0, key_valid=1 with key_code=5.
- Separately, assert reset during DEBOUNCE:
  - all outputs return to reset values and no pulse occurs.
